// File: rtl/bsg_manycore_endpoint_return_queue.sv
// bsg_manycore_endpoint_return_queue: in-order request/response matcher feeding the return-packet port
package bsg_manycore_pkg;
  localparam int bsg_manycore_reg_id_width_gp = 5;
  typedef enum logic [1:0] {
    e_return_credit,
    e_return_int_wb,
    e_return_float_wb,
    e_return_ifetch
  } bsg_manycore_return_packet_type_e;
endpackage

module bsg_manycore_endpoint_return_queue
  import bsg_manycore_pkg::*;
#(
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 3,
  parameter int data_width_p = 32,
  parameter int els_p = 2,
  parameter bit credit_bypass_p = 1'b0,
  localparam int return_packet_width_lp = $bits(bsg_manycore_return_packet_type_e) + data_width_p
                                          + y_cord_width_p + x_cord_width_p + bsg_manycore_reg_id_width_gp,
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     req_v_i,
  input  bsg_manycore_return_packet_type_e         req_pkt_type_i,
  input  logic [x_cord_width_p-1:0]                req_x_cord_i,
  input  logic [y_cord_width_p-1:0]                req_y_cord_i,
  input  logic [bsg_manycore_reg_id_width_gp-1:0]  req_reg_id_i,
  output logic                                     req_ready_o,
  input  logic                                     returning_v_i,
  input  logic [data_width_p-1:0]                  returning_data_i,
  output logic [return_packet_width_lp-1:0]        return_packet_o,
  output logic                                     return_packet_v_o,
  input  logic                                     return_packet_ready_i,
  output logic [cnt_width_lp-1:0]                  outstanding_o
);
  localparam int ptr_width_lp = els_p > 1 ? $clog2(els_p) : 1;
  localparam logic [ptr_width_lp-1:0] last_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] els_lp = cnt_width_lp'(els_p);

  typedef struct packed {
    bsg_manycore_return_packet_type_e pkt_type;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
    logic [bsg_manycore_reg_id_width_gp-1:0] reg_id;
    logic has_data;
  } meta_s;

  meta_s meta_q [els_p];
  meta_s meta_d [els_p];
  logic [data_width_p-1:0] data_q [els_p];
  logic [data_width_p-1:0] data_d [els_p];
  logic [ptr_width_lp-1:0] mw_q, mw_d, mr_q, mr_d, dw_q, dw_d, dr_q, dr_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d, dcnt_q, dcnt_d, ncnt_q, ncnt_d;
  logic take, deq, needs_in, pop_data;
  meta_s head;

  function automatic logic [ptr_width_lp-1:0] inc(input logic [ptr_width_lp-1:0] p);
    return p == last_lp ? '0 : p + 1'b1;
  endfunction

  assign req_ready_o = cnt_q < els_lp;
  assign outstanding_o = cnt_q;
  assign take = req_v_i & req_ready_o;
  assign needs_in = ~(credit_bypass_p & (req_pkt_type_i == e_return_credit));
  assign head = meta_q[mr_q];
  assign return_packet_v_o = (cnt_q != '0) & (~head.has_data | (dcnt_q != '0));
  assign deq = return_packet_v_o & return_packet_ready_i;
  assign pop_data = deq & head.has_data;
  assign return_packet_o = return_packet_v_o
    ? {head.pkt_type, head.has_data ? data_q[dr_q] : '0, head.y_cord, head.x_cord, head.reg_id}
    : '0;

  // next-state for pointers, occupancy counts and both storage arrays
  always_comb begin
    meta_d = meta_q;
    data_d = data_q;
    if (take) meta_d[mw_q] = '{req_pkt_type_i, req_y_cord_i, req_x_cord_i, req_reg_id_i, needs_in};
    if (returning_v_i) data_d[dw_q] = returning_data_i;
    mw_d = take ? inc(mw_q) : mw_q;
    mr_d = deq ? inc(mr_q) : mr_q;
    dw_d = returning_v_i ? inc(dw_q) : dw_q;
    dr_d = pop_data ? inc(dr_q) : dr_q;
    cnt_d = cnt_q + cnt_width_lp'(take) - cnt_width_lp'(deq);
    ncnt_d = ncnt_q + cnt_width_lp'(take & needs_in) - cnt_width_lp'(pop_data);
    dcnt_d = dcnt_q + cnt_width_lp'(returning_v_i) - cnt_width_lp'(pop_data);
  end

  // control state; reset drops every entry and any pending data at once
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mw_q <= '0;
      mr_q <= '0;
      dw_q <= '0;
      dr_q <= '0;
      cnt_q <= '0;
      ncnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      mw_q <= mw_d;
      mr_q <= mr_d;
      dw_q <= dw_d;
      dr_q <= dr_d;
      cnt_q <= cnt_d;
      ncnt_q <= ncnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  // storage needs no reset; the counts decide which slots are live
  always_ff @(posedge clk_i) begin
    meta_q <= meta_d;
    data_q <= data_d;
  end

  // a memory response must always have a needs-data entry waiting for it
  assert property (@(posedge clk_i) disable iff (reset_i) returning_v_i |-> ncnt_q != dcnt_q)
    else begin
      $error("returning_v_i with no entry awaiting data");
      $finish;
    end
endmodule

// File: tb/tb_bsg_manycore_endpoint_return_queue.sv
// tb_bsg_manycore_endpoint_return_queue: scoreboard bench for the return queue (els_p=3, credit bypass on)
module tb_bsg_manycore_endpoint_return_queue;
  import bsg_manycore_pkg::*;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int DW = 32;
  localparam int RW = bsg_manycore_reg_id_width_gp;
  localparam int ELS = 3;
  localparam int PW = 2 + DW + YW + XW + RW;
  localparam int CW = $clog2(ELS + 1);

  logic clk = 1'b0;
  logic reset_i;
  logic req_v_i;
  bsg_manycore_return_packet_type_e req_pkt_type_i;
  logic [XW-1:0] req_x_cord_i;
  logic [YW-1:0] req_y_cord_i;
  logic [RW-1:0] req_reg_id_i;
  logic req_ready_o;
  logic returning_v_i;
  logic [DW-1:0] returning_data_i;
  logic [PW-1:0] return_packet_o;
  logic return_packet_v_o;
  logic return_packet_ready_i;
  logic [CW-1:0] outstanding_o;

  logic [DW-1:0] req_data;
  logic [PW-1:0] exp_q [$];
  logic [PW-1:0] prev_pkt;
  logic hold = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bsg_manycore_endpoint_return_queue #(
    .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
    .els_p(ELS), .credit_bypass_p(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_pkt_type_i(req_pkt_type_i),
    .req_x_cord_i(req_x_cord_i), .req_y_cord_i(req_y_cord_i), .req_reg_id_i(req_reg_id_i),
    .req_ready_o(req_ready_o),
    .returning_v_i(returning_v_i), .returning_data_i(returning_data_i),
    .return_packet_o(return_packet_o), .return_packet_v_o(return_packet_v_o),
    .return_packet_ready_i(return_packet_ready_i), .outstanding_o(outstanding_o)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack(input bsg_manycore_return_packet_type_e t, input logic [DW-1:0] d,
                                         input logic [YW-1:0] y, input logic [XW-1:0] x, input logic [RW-1:0] r);
    return {t, d, y, x, r};
  endfunction

  // monitor: pop/compare on each return handshake, check hold-stability, push expectations on each take
  always @(negedge clk) begin
    if (reset_i) hold = 1'b0;
    else begin
      if (hold) begin
        check("hold_v", return_packet_v_o, 1);
        check("hold_pkt", return_packet_o, prev_pkt);
      end
      if (return_packet_v_o && return_packet_ready_i) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pkt: got %0h expected none", return_packet_o);
        end else check("pkt", return_packet_o, exp_q.pop_front());
      end
      if (req_v_i && req_ready_o)
        exp_q.push_back(pack(req_pkt_type_i, req_pkt_type_i == e_return_credit ? '0 : req_data,
                             req_y_cord_i, req_x_cord_i, req_reg_id_i));
      hold = return_packet_v_o && !return_packet_ready_i;
      prev_pkt = return_packet_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bsg_manycore_return_packet_type_e t, input logic [XW-1:0] x,
                         input logic [YW-1:0] y, input logic [RW-1:0] r, input logic [DW-1:0] d);
    req_pkt_type_i = t;
    req_x_cord_i = x;
    req_y_cord_i = y;
    req_reg_id_i = r;
    req_data = d;
  endtask

  task automatic req(input bsg_manycore_return_packet_type_e t, input logic [XW-1:0] x,
                     input logic [YW-1:0] y, input logic [RW-1:0] r, input logic [DW-1:0] d);
    set_req(t, x, y, r, d);
    req_v_i = 1'b1;
    tick();
    req_v_i = 1'b0;
  endtask

  task automatic ret(input logic [DW-1:0] d);
    returning_v_i = 1'b1;
    returning_data_i = d;
    tick();
    returning_v_i = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    return_packet_ready_i = 1'b1;
    for (int i = 0; i < 60 && outstanding_o != '0; i++) begin
      if (rnd) return_packet_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    return_packet_ready_i = 1'b0;
    check("drain_outstanding", outstanding_o, 0);
    check("drain_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset_i = 1'b1;
    req_v_i = 1'b0;
    returning_v_i = 1'b0;
    returning_data_i = '0;
    return_packet_ready_i = 1'b0;
    set_req(e_return_credit, '0, '0, '0, '0);
    tick();
    tick();
    check("rst_v", return_packet_v_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_req_ready", req_ready_o, 1);
    reset_i = 1'b0;
    tick();
    check("post_rst_req_ready", req_ready_o, 1);

    // single load, data two cycles after take
    return_packet_ready_i = 1'b1;
    req(e_return_int_wb, 4'd1, 3'd2, 5'd3, 32'hDEADBEEF);
    check("t1_outstanding", outstanding_o, 1);
    check("t1_v_wait", return_packet_v_o, 0);
    tick();
    ret(32'hDEADBEEF);
    check("t1_v", return_packet_v_o, 1);
    check("t1_pkt", return_packet_o, pack(e_return_int_wb, 32'hDEADBEEF, 3'd2, 4'd1, 5'd3));
    tick();
    check("t1_outstanding_done", outstanding_o, 0);
    check("t1_v_done", return_packet_v_o, 0);

    // fill to els_p, hold a 4th request, release one slot
    return_packet_ready_i = 1'b0;
    req(e_return_int_wb, 4'd2, 3'd3, 5'd4, 32'hA0);
    req(e_return_int_wb, 4'd2, 3'd3, 5'd5, 32'hA1);
    req(e_return_int_wb, 4'd2, 3'd3, 5'd6, 32'hA2);
    check("t2_full_ready", req_ready_o, 0);
    check("t2_full_out", outstanding_o, 3);
    ret(32'hA0);
    ret(32'hA1);
    ret(32'hA2);
    set_req(e_return_float_wb, 4'd7, 3'd1, 5'd7, 32'hA3);
    req_v_i = 1'b1;
    tick();
    tick();
    check("t2_blocked_out", outstanding_o, 3);
    return_packet_ready_i = 1'b1;
    tick();
    return_packet_ready_i = 1'b0;
    check("t2_ready_after_pop", req_ready_o, 1);
    check("t2_out_after_pop", outstanding_o, 2);
    tick();
    req_v_i = 1'b0;
    check("t2_fourth_taken", outstanding_o, 3);
    check("t2_full_again", req_ready_o, 0);
    ret(32'hA3);
    drain(1'b0);

    // credit bypass: store, load, store with a single memory response
    req(e_return_credit, 4'd3, 3'd1, 5'd8, 32'h0);
    check("t3_credit_v", return_packet_v_o, 1);
    check("t3_credit_pkt", return_packet_o, pack(e_return_credit, 32'h0, 3'd1, 4'd3, 5'd8));
    req(e_return_int_wb, 4'd3, 3'd1, 5'd9, 32'h55);
    req(e_return_credit, 4'd3, 3'd1, 5'd10, 32'h0);
    check("t3_out", outstanding_o, 3);
    ret(32'h55);
    drain(1'b0);

    // back-to-back loads with responses one cycle behind, random backpressure
    for (int i = 0; i < 4; i++) begin
      req_v_i = i < 3;
      set_req(e_return_int_wb, 4'(i), 3'(i), 5'(16 + i), 32'(16 + i));
      returning_v_i = i > 0;
      returning_data_i = 32'(15 + i);
      return_packet_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    req_v_i = 1'b0;
    returning_v_i = 1'b0;
    drain(1'b1);

    // take and return in the same cycle at outstanding=1
    req(e_return_credit, 4'd5, 3'd5, 5'd11, 32'h0);
    check("t5_out_pre", outstanding_o, 1);
    check("t5_v_pre", return_packet_v_o, 1);
    return_packet_ready_i = 1'b1;
    req(e_return_credit, 4'd6, 3'd6, 5'd12, 32'h0);
    return_packet_ready_i = 1'b0;
    check("t5_out_same", outstanding_o, 1);
    drain(1'b0);

    // reset mid-operation discards entries and waiting data
    req(e_return_int_wb, 4'd9, 3'd4, 5'd13, 32'hBAD0);
    req(e_return_int_wb, 4'd9, 3'd4, 5'd14, 32'hBAD1);
    ret(32'hBAD0);
    check("t6_v_pre", return_packet_v_o, 1);
    check("t6_out_pre", outstanding_o, 2);
    reset_i = 1'b1;
    returning_v_i = 1'b1;
    returning_data_i = 32'hBAD1;
    exp_q.delete();
    tick();
    reset_i = 1'b0;
    returning_v_i = 1'b0;
    check("t6_v_rst", return_packet_v_o, 0);
    check("t6_out_rst", outstanding_o, 0);
    check("t6_ready_rst", req_ready_o, 1);
    req(e_return_int_wb, 4'd10, 3'd7, 5'd15, 32'hC0FFEE);
    ret(32'hC0FFEE);
    check("t6_new_pkt", return_packet_o, pack(e_return_int_wb, 32'hC0FFEE, 3'd7, 4'd10, 5'd15));
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
